// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Register numbers, data width and the write-source encoding used by all files.
package rf_wb_arbiter_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    typedef logic [REG_W-1:0]  reg_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_t ZERO = 5'd0;
    localparam reg_t K0   = 5'd26;
    localparam reg_t K1   = 5'd27;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_MD   = 2'd2,
        SRC_EX   = 2'd3
    } src_e;

    // Register 0 is hardwired; writes to it are consumed but never committed.
    function automatic logic is_zero_reg(reg_t r);
        return r == ZERO;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of all request, grant, hazard and register-file signals around the arbiter.
// master = requesters/pipeline side, slave = the arbiter itself.
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic  wb_valid;
    reg_t  wb_rd;
    data_t wb_data;

    logic  md_valid;
    reg_t  md_rd;
    data_t md_data;
    logic  md_ready;

    logic  ex_valid;
    reg_t  ex_rd;
    data_t ex_data;
    logic  ex_ready;

    logic  issue_valid;
    reg_t  issue_rd;
    reg_t  rs_addr;
    reg_t  rt_addr;
    logic  rs_busy;
    logic  rt_busy;

    logic  pipe_freeze;
    logic  rf_wr;
    reg_t  rf_waddr;
    data_t rf_wdata;
    logic  waw_err;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output md_valid, md_rd, md_data,
        output ex_valid, ex_rd, ex_data,
        output issue_valid, issue_rd, rs_addr, rt_addr,
        input  md_ready, ex_ready, rs_busy, rt_busy,
        input  pipe_freeze, rf_wr, rf_waddr, rf_wdata, waw_err
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  md_valid, md_rd, md_data,
        input  ex_valid, ex_rd, ex_data,
        input  issue_valid, issue_rd, rs_addr, rt_addr,
        output md_ready, ex_ready, rs_busy, rt_busy,
        output pipe_freeze, rf_wr, rf_waddr, rf_wdata, waw_err
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard for in-flight mul/div results.
// Bit 0 never sets; an issue to a register wins over a same-cycle retirement of it.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_issue_valid,
    input  reg_t                i_issue_rd,
    input  logic                i_clr_valid,
    input  reg_t                i_clr_rd,
    input  reg_t                i_rs_addr,
    input  reg_t                i_rt_addr,
    output logic                o_rs_busy,
    output logic                o_rt_busy,
    output logic [NUM_REGS-1:0] o_pend
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_next;

    assign w_pend_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            logic w_set;
            logic w_clr;
            assign w_set = i_issue_valid && (i_issue_rd == REG_W'(gi));
            assign w_clr = i_clr_valid && (i_clr_rd == REG_W'(gi));
            assign w_pend_next[gi] = w_set || (r_pend[gi] && !w_clr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign o_rs_busy = r_pend[i_rs_addr];
    assign o_rt_busy = r_pend[i_rt_addr];
    assign o_pend    = r_pend;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single write-port arbiter: writeback has absolute priority, mul/div and exception
// share round-robin, and a starved secondary forces a one-cycle pipeline freeze.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic            clk,
    input  logic            reset,
    rf_wb_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_pipe_freeze;
    logic             r_waw_err;

    logic             w_rr_ptr_next;
    logic [CNT_W-1:0] w_starve_cnt_next;
    logic             w_pipe_freeze_next;
    logic             w_waw_err_next;

    src_e             w_src;
    logic             w_wb_grant;
    logic             w_md_grant;
    logic             w_ex_grant;
    logic             w_sec_valid;
    logic             w_sec_grant;
    logic             w_sec_starved;
    logic             w_rf_wr;
    reg_t             w_rf_waddr;
    data_t            w_rf_wdata;

    logic                w_rs_busy;
    logic                w_rt_busy;
    logic [NUM_REGS-1:0] w_pend;

    // Source selection; nothing is granted while reset is held.
    always_comb begin
        w_src = SRC_NONE;
        if (!reset) begin
            if (bus.wb_valid) begin
                w_src = SRC_WB;
            end else if (bus.md_valid && bus.ex_valid) begin
                w_src = r_rr_ptr ? SRC_EX : SRC_MD;
            end else if (bus.md_valid) begin
                w_src = SRC_MD;
            end else if (bus.ex_valid) begin
                w_src = SRC_EX;
            end
        end
    end

    assign w_wb_grant    = (w_src == SRC_WB);
    assign w_md_grant    = (w_src == SRC_MD);
    assign w_ex_grant    = (w_src == SRC_EX);
    assign w_sec_valid   = bus.md_valid || bus.ex_valid;
    assign w_sec_grant   = w_md_grant || w_ex_grant;
    assign w_sec_starved = w_sec_valid && !w_sec_grant;

    always_comb begin
        w_rf_waddr = ZERO;
        w_rf_wdata = '0;
        case (w_src)
            SRC_WB: begin
                w_rf_waddr = bus.wb_rd;
                w_rf_wdata = bus.wb_data;
            end
            SRC_MD: begin
                w_rf_waddr = bus.md_rd;
                w_rf_wdata = bus.md_data;
            end
            SRC_EX: begin
                w_rf_waddr = bus.ex_rd;
                w_rf_wdata = bus.ex_data;
            end
            default: begin
                w_rf_waddr = ZERO;
                w_rf_wdata = '0;
            end
        endcase
        w_rf_wr = (w_src != SRC_NONE) && !is_zero_reg(w_rf_waddr);
    end

    // After a secondary grant the other secondary source becomes favoured.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_md_grant) begin
            w_rr_ptr_next = 1'b1;
        end else if (w_ex_grant) begin
            w_rr_ptr_next = 1'b0;
        end
    end

    // Starvation count holds during a freeze so a wb that slips through keeps it armed.
    always_comb begin
        w_starve_cnt_next = r_starve_cnt;
        if (w_sec_grant || !w_sec_valid) begin
            w_starve_cnt_next = '0;
        end else if (r_pipe_freeze) begin
            w_starve_cnt_next = r_starve_cnt;
        end else if (r_starve_cnt < LIMIT) begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        if (r_pipe_freeze) begin
            w_pipe_freeze_next = w_sec_starved;
        end else begin
            w_pipe_freeze_next = w_sec_starved && (w_starve_cnt_next == LIMIT);
        end
    end

    assign w_waw_err_next = r_waw_err ||
                            (w_wb_grant && !is_zero_reg(bus.wb_rd) && w_pend[bus.wb_rd]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr      <= 1'b0;
            r_starve_cnt  <= '0;
            r_pipe_freeze <= 1'b0;
            r_waw_err     <= 1'b0;
        end else begin
            r_rr_ptr      <= w_rr_ptr_next;
            r_starve_cnt  <= w_starve_cnt_next;
            r_pipe_freeze <= w_pipe_freeze_next;
            r_waw_err     <= w_waw_err_next;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_issue_valid (bus.issue_valid),
        .i_issue_rd    (bus.issue_rd),
        .i_clr_valid   (w_md_grant),
        .i_clr_rd      (bus.md_rd),
        .i_rs_addr     (bus.rs_addr),
        .i_rt_addr     (bus.rt_addr),
        .o_rs_busy     (w_rs_busy),
        .o_rt_busy     (w_rt_busy),
        .o_pend        (w_pend)
    );

    assign bus.md_ready    = w_md_grant;
    assign bus.ex_ready    = w_ex_grant;
    assign bus.rs_busy     = w_rs_busy;
    assign bus.rt_busy     = w_rt_busy;
    assign bus.pipe_freeze = r_pipe_freeze;
    assign bus.rf_wr       = w_rf_wr;
    assign bus.rf_waddr    = w_rf_waddr;
    assign bus.rf_wdata    = w_rf_wdata;
    assign bus.waw_err     = r_waw_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scenario bench for rf_wb_arbiter: each task drives a cycle, queues the expected
// output vector, then pops and compares it mid-cycle.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mdr;
        logic        exr;
        logic        frz;
        logic        rsb;
        logic        rtb;
        logic        waw;
    } outs_t;

    typedef struct {
        string name;
        outs_t val;
        outs_t mask;
    } exp_t;

    localparam outs_t M_ALL    = '1;
    localparam outs_t M_NODATA = '{wr: 1'b1, addr: 5'd0, data: 32'd0, mdr: 1'b1,
                                   exr: 1'b1, frz: 1'b1, rsb: 1'b1, rtb: 1'b1, waw: 1'b1};

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic outs_t mk(logic wr, logic [4:0] addr, logic [31:0] data, logic mdr,
                                 logic exr, logic frz, logic rsb, logic rtb, logic waw);
        outs_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.mdr = mdr; v.exr = exr;
        v.frz = frz; v.rsb = rsb; v.rtb = rtb; v.waw = waw;
        return v;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.wr = bus.rf_wr; o.addr = bus.rf_waddr; o.data = bus.rf_wdata;
        o.mdr = bus.md_ready; o.exr = bus.ex_ready; o.frz = bus.pipe_freeze;
        o.rsb = bus.rs_busy; o.rtb = bus.rt_busy; o.waw = bus.waw_err;
        return o;
    endfunction

    task automatic push_exp(string n, outs_t v, outs_t m);
        exp_t e;
        e.name = n; e.val = v; e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; outs_t o;
        idle_inputs();
        reset = 1'b1;
        bus.md_valid = 1; bus.md_rd = 3; bus.md_data = 32'h0000_0333;
        bus.wb_valid = 1; bus.wb_rd = 6; bus.wb_data = 32'h0000_0666;
        next_cycle();
        push_exp("reset_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
        reset = 1'b0; bus.wb_valid = 0;
        push_exp("post_reset_md", mk(1, 3, 32'h0000_0333, 1, 0, 0, 0, 0, 0), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
        idle_inputs();
        push_exp("no_request", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
    endtask

    task automatic test_wb_priority();
        exp_t e; outs_t o;
        do_reset();
        bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hA5A5_A5A5;
        bus.md_valid = 1; bus.md_rd = 7; bus.md_data = 32'h1111_1111;
        bus.ex_valid = 1; bus.ex_rd = K1; bus.ex_data = 32'h2222_2222;
        push_exp("wb_priority", mk(1, 5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        exp_t e; outs_t o;
        do_reset();
        bus.md_valid = 1; bus.md_rd = 7;  bus.md_data = 32'h0000_0070;
        bus.ex_valid = 1; bus.ex_rd = K0; bus.ex_data = 32'h0000_0026;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp($sformatf("rr_md_%0d", i), mk(1, 7, 32'h70, 1, 0, 0, 0, 0, 0), M_ALL);
            else            push_exp($sformatf("rr_ex_%0d", i), mk(1, K0, 32'h26, 0, 1, 0, 0, 0, 0), M_ALL);
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        exp_t e; outs_t o;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            bus.md_valid = 1; bus.md_rd = 4; bus.md_data = 32'h44;
            bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'h55;
            for (int i = 0; i < 4; i++) begin
                push_exp($sformatf("starve_p%0d_c%0d", pass, i), mk(1, 5, 32'h55, 0, 0, 0, 0, 0, 0), M_ALL);
                #3; e = exp_q.pop_front(); o = sample(); checks++;
                if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
                else $display("txn %s out=%h", e.name, o);
                next_cycle();
            end
            if (pass == 1) begin
                // wb still present in the freeze cycle: granted, freeze extends
                push_exp("freeze_wb", mk(1, 5, 32'h55, 0, 0, 1, 0, 0, 0), M_ALL);
                #3; e = exp_q.pop_front(); o = sample(); checks++;
                if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
                else $display("txn %s out=%h", e.name, o);
                next_cycle();
            end
            bus.wb_valid = 0;
            push_exp($sformatf("freeze_md_p%0d", pass), mk(1, 4, 32'h44, 1, 0, 1, 0, 0, 0), M_ALL);
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
            bus.md_valid = 0;
            push_exp($sformatf("unfreeze_p%0d", pass), mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        exp_t e; outs_t o;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    bus.issue_valid = 1; bus.issue_rd = 9; bus.rs_addr = 9; bus.rt_addr = 10;
                    push_exp("sb_issue", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
                end
                1: begin
                    bus.rs_addr = 9; bus.rt_addr = 9;
                    push_exp("sb_busy", mk(0, 0, 0, 0, 0, 0, 1, 1, 0), M_ALL);
                end
                2: begin
                    bus.rs_addr = 9; bus.rt_addr = 9;
                    bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 32'h99;
                    push_exp("sb_md_grant", mk(1, 9, 32'h99, 1, 0, 0, 1, 1, 0), M_ALL);
                end
                3: begin
                    bus.rs_addr = 9; bus.rt_addr = 9;
                    push_exp("sb_cleared", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
                end
                4: begin
                    bus.issue_valid = 1; bus.issue_rd = 0;
                    push_exp("sb_issue_r0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
                end
                default: begin
                    push_exp("sb_r0_never_busy", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
                end
            endcase
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_set_wins_waw();
        exp_t e; outs_t o;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            bus.rs_addr = 9;
            case (c)
                0: begin
                    bus.issue_valid = 1; bus.issue_rd = 9;
                    push_exp("sw_issue", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
                end
                1: begin
                    bus.issue_valid = 1; bus.issue_rd = 9;
                    bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 32'h9009;
                    push_exp("sw_set_and_clr", mk(1, 9, 32'h9009, 1, 0, 0, 1, 0, 0), M_ALL);
                end
                2: begin
                    bus.wb_valid = 1; bus.wb_rd = 9; bus.wb_data = 32'h1234;
                    push_exp("sw_set_won_wb", mk(1, 9, 32'h1234, 0, 0, 0, 1, 0, 0), M_ALL);
                end
                3, 4: push_exp($sformatf("waw_sticky_%0d", c), mk(0, 0, 0, 0, 0, 0, 1, 0, 1), M_ALL);
                5: begin
                    reset = 1'b1;
                    bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 32'h77;
                    push_exp("waw_in_reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 1), M_ALL);
                end
                default: begin
                    reset = 1'b0;
                    push_exp("waw_cleared", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
                end
            endcase
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_zero_write();
        exp_t e; outs_t o;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            case (c)
                0: begin
                    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hDEAD_BEEF;
                    bus.md_valid = 1; bus.md_rd = 8; bus.md_data = 32'h88;
                    push_exp("wb_r0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_NODATA);
                end
                1: begin
                    bus.md_valid = 1; bus.md_rd = 8; bus.md_data = 32'h88;
                    push_exp("md_after_wb_r0", mk(1, 8, 32'h88, 1, 0, 0, 0, 0, 0), M_ALL);
                end
                2: begin
                    bus.md_valid = 1; bus.md_rd = 0; bus.md_data = 32'hCAFE;
                    push_exp("md_r0", mk(0, 0, 0, 1, 0, 0, 0, 0, 0), M_NODATA);
                end
                default: push_exp("zero_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
            endcase
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if ((o & e.mask) !== (e.val & e.mask)) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; outs_t o;
        do_reset();
        bus.issue_valid = 1; bus.issue_rd = 12; bus.rs_addr = 12;
        push_exp("rm_issue", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
        bus.issue_valid = 0;
        bus.md_valid = 1; bus.md_rd = 3; bus.md_data = 32'h33;
        bus.wb_valid = 1; bus.wb_rd = 12; bus.wb_data = 32'hC0C0;
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("rm_starve_%0d", i), mk(1, 12, 32'hC0C0, 0, 0, 0, 1, 0, i > 0), M_ALL);
            #3; e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
            else $display("txn %s out=%h", e.name, o);
            next_cycle();
        end
        reset = 1'b1;
        push_exp("rm_reset_in_freeze", mk(0, 0, 0, 0, 0, 1, 1, 0, 1), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        bus.rs_addr = 12;
        push_exp("rm_after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        #3; e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, o, e.val); end
        else $display("txn %s out=%h", e.name, o);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_wb_priority();
        test_round_robin();
        test_starvation();
        test_scoreboard();
        test_set_wins_waw();
        test_zero_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends even if a task stalls.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
